// File: rtl/riscv_pkg.sv
// Shared types for the pipeline's memory arbiter: FSM states and transaction owner.
package riscv_pkg;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {ARB_IDLE, ARB_ISSUE, ARB_WAIT, ARB_RESP} arb_state_t;
  typedef enum logic {OWN_IF, OWN_DM} arb_owner_t;

endpackage

// File: rtl/mem_arb_picker.sv
// Priority picker between IF and DM requests; data wins unless IF has been starved STARVE_MAX times.
module mem_arb_picker import riscv_pkg::*; #(
  parameter int STARVE_MAX = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic arb_en,
  input  logic if_req,
  input  logic dm_req,
  input  logic if_flush,
  output logic grant_if,
  output logic grant_dm
);

  localparam int CW = $clog2(STARVE_MAX + 1);

  logic [CW-1:0] starve_cnt;
  logic          starved;
  arb_owner_t    pick;

  assign starved = (starve_cnt == CW'(STARVE_MAX));

  always_comb begin
    pick = OWN_DM;
    if (if_req && (!dm_req || starved)) pick = OWN_IF;
  end

  // A redirect arriving while IF is selected cancels the grant outright for this cycle.
  assign grant_if = arb_en && if_req && (pick == OWN_IF) && !if_flush;
  assign grant_dm = arb_en && dm_req && (pick == OWN_DM);

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (arb_en) begin
      if (!if_req || grant_if) begin
        starve_cnt <= '0;
      end else if (grant_dm && !starved) begin
        starve_cnt <= starve_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/unified_mem_arbiter.sv
// Shares one single-ported memory between instruction fetch and data memory, one transaction at a time.
module unified_mem_arbiter #(
  parameter int XLEN       = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_req,
  input  logic [XLEN-1:0] if_addr,
  input  logic            if_flush,
  output logic            if_done,
  output logic [XLEN-1:0] if_rdata,
  input  logic            dm_req,
  input  logic            dm_we,
  input  logic [XLEN-1:0] dm_addr,
  input  logic [XLEN-1:0] dm_wdata,
  input  logic [3:0]      dm_be,
  output logic            dm_done,
  output logic [XLEN-1:0] dm_rdata,
  output logic            mem_req,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  output logic [3:0]      mem_be,
  input  logic            mem_gnt,
  input  logic            mem_rvalid,
  input  logic [XLEN-1:0] mem_rdata
);

  import riscv_pkg::*;

  arb_state_t      state, state_next;
  arb_owner_t      owner;
  logic            flush_pend;
  logic [XLEN-1:0] rdata_q;
  logic            grant_if, grant_dm;
  logic            resp_if, resp_dm;

  mem_arb_picker #(.STARVE_MAX(STARVE_MAX)) u_picker (
    .clk      (clk),
    .rst      (rst),
    .arb_en   (state == ARB_IDLE),
    .if_req   (if_req),
    .dm_req   (dm_req),
    .if_flush (if_flush),
    .grant_if (grant_if),
    .grant_dm (grant_dm)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= ARB_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ARB_IDLE:  if (grant_if || grant_dm) state_next = ARB_ISSUE;
      ARB_ISSUE: if (mem_gnt)              state_next = ARB_WAIT;
      ARB_WAIT:  if (mem_rvalid)           state_next = ARB_RESP;
      ARB_RESP:                            state_next = ARB_IDLE;
      default:                             state_next = ARB_IDLE;
    endcase
  end

  // A flush landing in the response cycle itself must still swallow the IF result.
  always_comb begin
    mem_req  = (state == ARB_ISSUE);
    resp_if  = (state == ARB_RESP) && (owner == OWN_IF) && !flush_pend && !if_flush;
    resp_dm  = (state == ARB_RESP) && (owner == OWN_DM);
    if_done  = resp_if;
    dm_done  = resp_dm;
    if_rdata = resp_if ? rdata_q : '0;
    dm_rdata = (resp_dm && !mem_we) ? rdata_q : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      owner      <= OWN_IF;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_be     <= '0;
      rdata_q    <= '0;
      flush_pend <= 1'b0;
    end else begin
      if (grant_if) begin
        owner     <= OWN_IF;
        mem_we    <= 1'b0;
        mem_addr  <= if_addr;
        mem_wdata <= '0;
        mem_be    <= '0;
      end else if (grant_dm) begin
        owner     <= OWN_DM;
        mem_we    <= dm_we;
        mem_addr  <= dm_addr;
        mem_wdata <= dm_we ? dm_wdata : '0;
        mem_be    <= dm_we ? dm_be : 4'h0;
      end
      if (state == ARB_WAIT && mem_rvalid) rdata_q <= mem_rdata;
      if (state == ARB_IDLE) begin
        flush_pend <= 1'b0;
      end else if (owner == OWN_IF && if_flush) begin
        flush_pend <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Directed self-checking bench for unified_mem_arbiter with hand-computed expectations.
module tb_unified_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic        if_flush = 1'b0;
  logic        if_done;
  logic [31:0] if_rdata;
  logic        dm_req = 1'b0;
  logic        dm_we = 1'b0;
  logic [31:0] dm_addr = '0;
  logic [31:0] dm_wdata = '0;
  logic [3:0]  dm_be = '0;
  logic        dm_done;
  logic [31:0] dm_rdata;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_gnt = 1'b0;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = '0;

  int checks = 0;
  int errors = 0;

  unified_mem_arbiter #(.XLEN(32), .STARVE_MAX(4)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
    .if_done(if_done), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_be(dm_be),
    .dm_done(dm_done), .dm_rdata(dm_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if ({mem_req, mem_we, if_done, dm_done} !== 4'b0000 || mem_addr !== 32'h0 || if_rdata !== 32'h0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: req/we/ifd/dmd=%b%b%b%b addr=%h, required all 0", mem_req, mem_we, if_done, dm_done, mem_addr);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_if_only();
    if_req = 1'b1; if_addr = 32'h10;
    tick();
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h10 || mem_we !== 1'b0) begin
      errors++;
      $display("[TB] FAIL if_issue: req=%b addr=%h we=%b, required 1 00000010 0", mem_req, mem_addr, mem_we);
    end
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    checks++;
    if (mem_req !== 1'b0) begin
      errors++;
      $display("[TB] FAIL if_req_drop: mem_req=%b, required 0", mem_req);
    end
    mem_rvalid = 1'b1; mem_rdata = 32'h00A00093;
    tick();
    mem_rvalid = 1'b0;
    checks++;
    if (if_done !== 1'b1 || if_rdata !== 32'h00A00093 || dm_done !== 1'b0) begin
      errors++;
      $display("[TB] FAIL if_done: done=%b rdata=%h dm_done=%b, required 1 00a00093 0", if_done, if_rdata, dm_done);
    end
    if_req = 1'b0;
    tick();
    checks++;
    if (if_done !== 1'b0) begin
      errors++;
      $display("[TB] FAIL if_done_pulse: done=%b, required 0", if_done);
    end
  endtask

  task automatic test_dm_first();
    int dm_cyc, if_cyc;
    if_req = 1'b1; if_addr = 32'h20;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h100; dm_wdata = 32'hFFFF; dm_be = 4'hF;
    tick();
    checks++;
    if (mem_addr !== 32'h100 || mem_we !== 1'b0 || mem_wdata !== 32'h0 || mem_be !== 4'h0) begin
      errors++;
      $display("[TB] FAIL dm_first_issue: addr=%h we=%b wdata=%h be=%h, required 00000100 0 0 0", mem_addr, mem_we, mem_wdata, mem_be);
    end
    mem_gnt = 1'b1; tick(); mem_gnt = 1'b0;
    mem_rvalid = 1'b1; mem_rdata = 32'hDEADBEEF; tick(); mem_rvalid = 1'b0;
    dm_cyc = 3;
    checks++;
    if (dm_done !== 1'b1 || dm_rdata !== 32'hDEADBEEF || if_done !== 1'b0) begin
      errors++;
      $display("[TB] FAIL dm_first_done: dm_done=%b rdata=%h if_done=%b, required 1 deadbeef 0", dm_done, dm_rdata, if_done);
    end
    dm_req = 1'b0;
    tick(); tick();
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h20) begin
      errors++;
      $display("[TB] FAIL if_second_issue: req=%b addr=%h, required 1 00000020", mem_req, mem_addr);
    end
    mem_gnt = 1'b1; tick(); mem_gnt = 1'b0;
    mem_rvalid = 1'b1; mem_rdata = 32'h00200113; tick(); mem_rvalid = 1'b0;
    if_cyc = 7;
    checks++;
    if (if_done !== 1'b1 || if_rdata !== 32'h00200113 || (if_cyc - dm_cyc) !== 4) begin
      errors++;
      $display("[TB] FAIL if_second_done: done=%b rdata=%h, required 1 00200113 four cycles after dm_done", if_done, if_rdata);
    end
    if_req = 1'b0;
    tick();
  endtask

  task automatic test_starvation();
    logic [31:0] exp_addr [6];
    exp_addr = '{32'h300, 32'h300, 32'h300, 32'h300, 32'h40, 32'h300};
    if_req = 1'b1; if_addr = 32'h40;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h300;
    for (int t = 0; t < 6; t++) begin
      int waited = 0;
      tick();
      while (mem_req !== 1'b1 && waited < 8) begin
        tick();
        waited++;
      end
      checks++;
      if (mem_req !== 1'b1 || mem_addr !== exp_addr[t]) begin
        errors++;
        $display("[TB] FAIL starve_grant_%0d: req=%b addr=%h, required 1 %h", t, mem_req, mem_addr, exp_addr[t]);
      end
      mem_gnt = 1'b1; tick(); mem_gnt = 1'b0;
      mem_rvalid = 1'b1; mem_rdata = 32'h1000 + t; tick(); mem_rvalid = 1'b0;
      checks++;
      if (if_done !== (exp_addr[t] == 32'h40) || dm_done !== (exp_addr[t] == 32'h300)) begin
        errors++;
        $display("[TB] FAIL starve_done_%0d: if_done=%b dm_done=%b, required %b %b", t, if_done, dm_done,
                 exp_addr[t] == 32'h40, exp_addr[t] == 32'h300);
      end
    end
    if_req = 1'b0; dm_req = 1'b0;
    tick(); tick();
  endtask

  task automatic test_store();
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h200; dm_wdata = 32'h14; dm_be = 4'hF;
    tick();
    checks++;
    if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'h200 || mem_wdata !== 32'h14 || mem_be !== 4'hF) begin
      errors++;
      $display("[TB] FAIL store_issue: req=%b we=%b addr=%h wdata=%h be=%h, required 1 1 00000200 00000014 f",
               mem_req, mem_we, mem_addr, mem_wdata, mem_be);
    end
    mem_gnt = 1'b1; tick(); mem_gnt = 1'b0;
    mem_rvalid = 1'b1; mem_rdata = 32'h55555555; tick(); mem_rvalid = 1'b0;
    checks++;
    if (dm_done !== 1'b1 || dm_rdata !== 32'h0) begin
      errors++;
      $display("[TB] FAIL store_done: dm_done=%b rdata=%h, required 1 0", dm_done, dm_rdata);
    end
    dm_req = 1'b0; dm_we = 1'b0;
    tick();
  endtask

  task automatic test_flush();
    if_req = 1'b1; if_addr = 32'h80; if_flush = 1'b1;
    tick();
    checks++;
    if (mem_req !== 1'b0) begin
      errors++;
      $display("[TB] FAIL flush_idle_block: mem_req=%b, required 0", mem_req);
    end
    if_flush = 1'b0;
    tick();
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h80) begin
      errors++;
      $display("[TB] FAIL flush_issue: req=%b addr=%h, required 1 00000080", mem_req, mem_addr);
    end
    mem_gnt = 1'b1; tick(); mem_gnt = 1'b0;
    if_flush = 1'b1; tick(); if_flush = 1'b0;
    tick(); tick();
    mem_rvalid = 1'b1; mem_rdata = 32'h1234; tick(); mem_rvalid = 1'b0;
    checks++;
    if (if_done !== 1'b0 || if_rdata !== 32'h0) begin
      errors++;
      $display("[TB] FAIL flush_suppress: if_done=%b rdata=%h, required 0 0", if_done, if_rdata);
    end
    if_req = 1'b0;
    tick();
    if_req = 1'b1; if_addr = 32'h84;
    tick();
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h84) begin
      errors++;
      $display("[TB] FAIL post_flush_issue: req=%b addr=%h, required 1 00000084", mem_req, mem_addr);
    end
    mem_gnt = 1'b1; tick(); mem_gnt = 1'b0;
    mem_rvalid = 1'b1; mem_rdata = 32'h00B00113; tick(); mem_rvalid = 1'b0;
    checks++;
    if (if_done !== 1'b1 || if_rdata !== 32'h00B00113) begin
      errors++;
      $display("[TB] FAIL post_flush_done: done=%b rdata=%h, required 1 00b00113", if_done, if_rdata);
    end
    if_req = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    if_req = 1'b1; if_addr = 32'h90;
    tick();
    mem_gnt = 1'b1; tick(); mem_gnt = 1'b0;
    rst = 1'b1;
    tick();
    checks++;
    if (mem_req !== 1'b0 || mem_addr !== 32'h0 || if_done !== 1'b0 || dm_done !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_mid: req=%b addr=%h ifd=%b dmd=%b, required 0 0 0 0", mem_req, mem_addr, if_done, dm_done);
    end
    rst = 1'b0; if_req = 1'b0;
    mem_rvalid = 1'b1; mem_rdata = 32'hBAD;
    tick();
    mem_rvalid = 1'b0;
    checks++;
    if (if_done !== 1'b0 || dm_done !== 1'b0 || mem_req !== 1'b0) begin
      errors++;
      $display("[TB] FAIL stray_rvalid_a: ifd=%b dmd=%b req=%b, required 0 0 0", if_done, dm_done, mem_req);
    end
    tick();
    checks++;
    if (if_done !== 1'b0 || dm_done !== 1'b0 || if_rdata !== 32'h0) begin
      errors++;
      $display("[TB] FAIL stray_rvalid_b: ifd=%b dmd=%b rdata=%h, required 0 0 0", if_done, dm_done, if_rdata);
    end
  endtask

  initial begin
    test_reset();
    test_if_only();
    test_dm_first();
    test_starvation();
    test_store();
    test_flush();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
